// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Pipeline write-back stage. Turns MEM-stage results into
//               register-file writes and waits (bounded) for load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic [4:0]  Dest_in,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        WB_Write_Enable,
  output logic [4:0]  WB_Dest,
  output logic [31:0] WB_Data,
  output logic        stall,
  output logic        mem_timeout,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_wb_dest;
  logic [31:0] r_wb_data;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;
  logic [15:0] r_retired_count;

  logic w_in_ready;
  logic w_accept;
  logic w_real_write;
  logic w_wait_expired;
  logic w_timeout_hit;

  assign w_in_ready     = (r_state != WAIT_MEM);
  assign w_accept       = in_valid & w_in_ready;
  // Writes to register $0 are architecturally discarded, so treat them as no-ops.
  assign w_real_write   = WB_EN_in & (Dest_in != 5'd0);
  assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE, WRITE: begin
        if (w_accept && w_real_write)
          w_next_state = MEM_R_EN_in ? WAIT_MEM : WRITE;
        else
          w_next_state = IDLE;
      end
      WAIT_MEM: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          w_next_state = WRITE;
        end else if (w_wait_expired) begin
          w_next_state  = IDLE;
          w_timeout_hit = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_wb_dest       <= 5'd0;
      r_wb_data       <= 32'd0;
      r_wait_cnt      <= 8'd0;
      r_mem_timeout   <= 1'b0;
      r_retired_count <= 16'd0;
    end else begin
      r_state <= w_next_state;

      if (w_accept && w_real_write) begin
        r_wb_dest  <= Dest_in;
        r_wait_cnt <= 8'd0;
        if (!MEM_R_EN_in)
          r_wb_data <= ALU_Result;
      end

      if (r_state == WAIT_MEM) begin
        if (mem_ready)
          r_wb_data <= mem_rdata;
        else if (!w_wait_expired)
          r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (w_timeout_hit)
        r_mem_timeout <= 1'b1;

      // Counted on entry so the count already includes the write being strobed.
      if (w_next_state == WRITE)
        r_retired_count <= r_retired_count + 16'd1;
    end
  end

  assign in_ready        = w_in_ready;
  assign stall           = ~w_in_ready;
  assign WB_Write_Enable = (r_state == WRITE);
  assign WB_Dest         = r_wb_dest;
  assign WB_Data         = r_wb_data;
  assign mem_timeout     = r_mem_timeout;
  assign retired_count   = r_retired_count;

endmodule

`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum number of cycles spent in WAIT_MEM before a load is abandoned (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, a MEM-stage result is presented this cycle.
REQ-005 SHALL have port in_ready, output, 1, wb_stage accepts the presented result this cycle.
REQ-006 SHALL have port WB_EN_in, input, 1, the instruction writes a register.
REQ-007 SHALL have port MEM_R_EN_in, input, 1, the instruction is a load.
REQ-008 SHALL have port Dest_in, input, 5, destination register number.
REQ-009 SHALL have port ALU_Result, input, 32, EXE result for non-load writes.
REQ-010 SHALL have port mem_rdata, input, 32, load data, valid only when mem_ready=1.
REQ-011 SHALL have port mem_ready, input, 1, load data valid pulse from data memory.
REQ-012 SHALL have port WB_Write_Enable, output, 1, register-file write strobe toward the ID stage.
REQ-013 SHALL have port WB_Dest, output, 5, register-file write address.
REQ-014 SHALL have port WB_Data, output, 32, register-file write data.
REQ-015 SHALL have port stall, output, 1, freeze request to upstream stages; equals ~in_ready.
REQ-016 SHALL have port mem_timeout, output, 1, sticky flag: a load was abandoned.
REQ-017 SHALL have port retired_count, output, 16, count of register writes performed.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT_MEM and WRITE.
REQ-019 SHALL drive in_ready=1 in IDLE and WRITE, and in_ready=0 in WAIT_MEM.
REQ-020 SHALL accept a result when in_valid & in_ready.
REQ-021 On an accepted result with WB_EN_in=1, MEM_R_EN_in=0 and Dest_in!=0, SHALL latch WB_Dest<=Dest_in and WB_Data<=ALU_Result, then enter WRITE.
REQ-022 On an accepted result with WB_EN_in=1, MEM_R_EN_in=1 and Dest_in!=0, SHALL latch WB_Dest<=Dest_in, clear wait_cnt to 0, then enter WAIT_MEM.
REQ-023 On an accepted result with WB_EN_in=0 or Dest_in==0 (writes to $0 are suppressed), SHALL enter IDLE and leave WB_Dest/WB_Data unchanged.
REQ-024 With no result accepted in IDLE or WRITE, SHALL enter IDLE.
REQ-025 In WAIT_MEM with mem_ready=1, SHALL latch WB_Data<=mem_rdata and enter WRITE.
REQ-026 In WAIT_MEM with mem_ready=0 and wait_cnt==TIMEOUT-1, SHALL set mem_timeout=1, enter IDLE and perform no write.
REQ-027 In WAIT_MEM with mem_ready=0 and wait_cnt<TIMEOUT-1, SHALL increment wait_cnt and stay in WAIT_MEM.
REQ-028 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-029 SHALL ignore mem_ready in IDLE and WRITE.
REQ-030 SHALL assert WB_Write_Enable=1 exactly while in WRITE, one cycle per write.
REQ-031 SHALL hold WB_Dest/WB_Data stable between writes.
REQ-032 SHALL make a non-load write visible as WB_Write_Enable one cycle after acceptance, giving back-to-back throughput of one per cycle.
REQ-033 SHALL make a load write visible one cycle after mem_ready.
REQ-034 SHALL increment retired_count (modulo 2^16, wrapping 0xFFFF->0x0000) on every WRITE cycle.
REQ-035 SHALL keep mem_timeout set until reset once it is set.

Reset
REQ-036 SHALL, while rst=1 and independent of clk, force: state=IDLE, WB_Write_Enable=0, WB_Dest=0, WB_Data=0, wait_cnt=0, mem_timeout=0, retired_count=0, in_ready=1, stall=0.
REQ-037 SHALL, on reset asserted mid-WAIT_MEM or mid-WRITE, discard the pending write (no strobe); a mem_ready arriving after reset SHALL be ignored.

Verification
REQ-038 SHALL verify ALU write: in_valid=1, WB_EN_in=1, MEM_R_EN_in=0, Dest_in=5, ALU_Result=0x1234_5678 -> next cycle WB_Write_Enable=1, WB_Dest=5, WB_Data=0x12345678; retired_count=1.
REQ-039 SHALL verify load: load to Dest_in=9, mem_ready after 3 cycles with mem_rdata=0xDEAD_BEEF -> stall=1 for 3 cycles, then one strobe with WB_Dest=9, WB_Data=0xDEADBEEF.
REQ-040 SHALL verify $0 and no-write cases: Dest_in=0 with WB_EN_in=1, and Dest_in=7 with WB_EN_in=0 -> no strobe, WB_Dest/WB_Data unchanged, retired_count unchanged.
REQ-041 SHALL verify timeout: TIMEOUT=4, load with no mem_ready -> 4 WAIT_MEM cycles, then mem_timeout=1, IDLE, no strobe; a late mem_ready is ignored.
REQ-042 SHALL verify back-to-back: 3 consecutive ALU writes to regs 1,2,3 -> 3 consecutive strobes, in_ready constantly 1.
REQ-043 SHALL verify async reset: rst pulse during WAIT_MEM between clock edges -> outputs immediately at reset values, no subsequent strobe.
